// File: rtl/flopenr_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : flopenr_write_arbiter_pkg
//  Brief    : Shared constants, state encoding and width helper for the arbiter
//  Revision : 1.0
// ============================================================================
package flopenr_write_arbiter_pkg;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_MAX_LOCK = 4;
    localparam int DEF_WIDTH    = 32;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE   = 1'b0;
    localparam state_t ST_LOCKED = 1'b1;

    // Bits needed to index v items, never less than one
    function automatic int clog2_min1(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flopenr_write_arbiter_flopenr_32.sv
`default_nettype none
// ============================================================================
//  Module   : Flopenr_32
//  Brief    : 32-bit enabled flop with synchronous active-high reset
//  Revision : 1.0
// ============================================================================
module Flopenr_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        E,
    input  logic [31:0] D,
    output logic [31:0] Q
);

    always_ff @(posedge clk) begin
        if (reset)  Q <= '0;
        else if (E) Q <= D;
    end

endmodule
`default_nettype wire

// File: rtl/flopenr_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Brief    : Round-robin picker: first set request at or after ptr, with wrap
//  Revision : 1.0
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [PW-1:0]    idx,
    output logic             any
);

    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!any && req[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                idx       = PW'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/flopenr_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : flopenr_write_arbiter
//  Brief    : Round-robin write arbiter with bounded lock for one 32-bit register
//  Revision : 1.0
// ============================================================================
module flopenr_write_arbiter
    import flopenr_write_arbiter_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int MAX_LOCK = DEF_MAX_LOCK,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       ack,
    output logic                   owner_valid,
    output logic [WIDTH-1:0]       Q
);

    localparam int c_ptr_w = clog2_min1(N_REQ);
    localparam int c_cnt_w = clog2_min1(MAX_LOCK + 1);

    state_t             r_state;
    logic [c_ptr_w-1:0] r_ptr;
    logic [c_ptr_w-1:0] r_owner;
    logic [c_cnt_w-1:0] r_lock_cnt;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_ack;

    state_t             w_state_nxt;
    logic [c_ptr_w-1:0] w_ptr_nxt;
    logic [c_ptr_w-1:0] w_owner_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [N_REQ-1:0]   w_grant_nxt;
    logic [N_REQ-1:0]   w_ack_nxt;
    logic               w_we;
    logic [WIDTH-1:0]   w_d;

    logic [N_REQ-1:0]   w_win_oh;
    logic [c_ptr_w-1:0] w_win_idx;
    logic               w_any;
    logic [N_REQ-1:0]   w_owner_oh;
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic               w_enter;
    logic               w_exit;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (c_ptr_w)
    ) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .onehot (w_win_oh),
        .idx    (w_win_idx),
        .any    (w_any)
    );

    assign w_owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;
    assign w_cnt_inc  = r_lock_cnt + c_cnt_w'(1);
    // MAX_LOCK counts every write of a locked burst, the entry write included,
    // so a limit of one never enters LOCKED and the exit compares the new count.
    assign w_enter    = w_any && lock[w_win_idx] && (MAX_LOCK > 1);
    assign w_exit     = !lock[r_owner] || (w_cnt_inc == c_cnt_w'(MAX_LOCK));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_lock_cnt <= '0;
            r_grant    <= '0;
            r_ack      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_lock_cnt <= w_cnt_nxt;
            r_grant    <= w_grant_nxt;
            r_ack      <= w_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_enter) w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (w_exit)  w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_lock_cnt;
        w_grant_nxt = '0;
        w_ack_nxt   = '0;
        w_we        = 1'b0;
        w_d         = wdata[r_owner*WIDTH +: WIDTH];
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_we        = 1'b1;
                    w_d         = wdata[w_win_idx*WIDTH +: WIDTH];
                    w_ack_nxt   = w_win_oh;
                    w_grant_nxt = w_win_oh;
                    w_ptr_nxt   = (w_win_idx == c_ptr_w'(N_REQ-1)) ? '0
                                                                   : w_win_idx + c_ptr_w'(1);
                    if (w_enter) begin
                        w_owner_nxt = w_win_idx;
                        w_cnt_nxt   = c_cnt_w'(1);
                    end
                end
            end
            ST_LOCKED: begin
                w_we      = req[r_owner];
                w_ack_nxt = req[r_owner] ? w_owner_oh : '0;
                w_cnt_nxt = w_exit ? '0 : w_cnt_inc;
                if (!w_exit) w_grant_nxt = w_owner_oh;
            end
            default: ;
        endcase
    end

    assign grant       = r_grant;
    assign ack         = r_ack;
    assign owner_valid = (r_state == ST_LOCKED);

    Flopenr_32 u_store (
        .clk   (clk),
        .reset (reset),
        .E     (w_we),
        .D     (w_d),
        .Q     (Q)
    );

endmodule
`default_nettype wire
